// File: rtl/seq101_pkg.sv
// Shared state encodings for the dual "101" serial pattern detector.
package seq101_pkg;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_1    = 2'd1,
        M_10   = 2'd2
    } mealy_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_10   = 2'd2,
        S_101  = 2'd3
    } moore_state_t;

    localparam logic [2:0] PATTERN = 3'b101;

endpackage

// File: rtl/seq101_dual_detector_if.sv
// Serial bit in, Mealy and Moore detect pulses out.
interface seq101_dual_detector_if;

    logic x;
    logic y_mealy;
    logic y_moore;

    modport master (
        output x,
        input  y_mealy,
        input  y_moore
    );

    modport slave (
        input  x,
        output y_mealy,
        output y_moore
    );

endinterface

// File: rtl/seq101_moore_fsm.sv
// Moore "101" matcher: the detect pulse is a pure decode of the state register.
module seq101_moore_fsm
    import seq101_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y_moore
);

    moore_state_t state;
    moore_state_t state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving S_101 on a 0 keeps the trailing "10" only when overlapping hits are wanted.
    always_comb begin
        state_next = S_IDLE;
        y_moore    = 1'b0;
        case (state)
            S_IDLE: state_next = x ? S_1 : S_IDLE;
            S_1:    state_next = x ? S_1 : S_10;
            S_10:   state_next = x ? S_101 : S_IDLE;
            S_101: begin
                y_moore = 1'b1;
                if (x) begin
                    state_next = S_1;
                end else begin
                    state_next = OVERLAP ? S_10 : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: rtl/seq101_dual_detector.sv
// Runs a Mealy and a Moore "101" matcher side by side on one serial stream.
module seq101_dual_detector
    import seq101_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    seq101_dual_detector_if.slave bus
);

    mealy_state_t mealy_state;
    mealy_state_t mealy_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mealy_state <= M_IDLE;
        end else begin
            mealy_state <= mealy_next;
        end
    end

    // The final '1' of a match completes the pattern in the same cycle it is presented.
    always_comb begin
        mealy_next  = M_IDLE;
        bus.y_mealy = 1'b0;
        case (mealy_state)
            M_IDLE: mealy_next = bus.x ? M_1 : M_IDLE;
            M_1:    mealy_next = bus.x ? M_1 : M_10;
            M_10: begin
                if (bus.x) begin
                    bus.y_mealy = 1'b1;
                    mealy_next  = OVERLAP ? M_1 : M_IDLE;
                end else begin
                    mealy_next  = M_IDLE;
                end
            end
            default: mealy_next = M_IDLE;
        endcase
    end

    seq101_moore_fsm #(
        .OVERLAP (OVERLAP)
    ) u_moore (
        .clk     (clk),
        .reset   (reset),
        .x       (bus.x),
        .y_moore (bus.y_moore)
    );

endmodule

// File: tb/tb_seq101_dual_detector.sv
// Drives overlapping and non-overlapping detectors with one stream and checks both against a history model.
module tb_seq101_dual_detector;

    logic clk;
    logic reset;

    seq101_dual_detector_if bus_ov ();
    seq101_dual_detector_if bus_no ();

    seq101_dual_detector #(.OVERLAP(1'b1)) dut_ov (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_ov.slave)
    );

    seq101_dual_detector #(.OVERLAP(1'b0)) dut_no (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_no.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model: bits seen since the matcher last restarted; a hit is "1","0" followed by a presented '1'.
    int   hist_ov[$];
    int   hist_no[$];
    logic moore_exp_ov = 1'b0;
    logic moore_exp_no = 1'b0;

    logic [31:0] mask_m_ov, mask_y_ov, mask_m_no, mask_y_no;

    function automatic logic would_hit(input int hist[$], input logic b);
        int n;
        n = hist.size();
        return (n >= 2) && (hist[n-2] == 1) && (hist[n-1] == 0) && b;
    endfunction

    task automatic model_reset();
        hist_ov.delete();
        hist_no.delete();
        moore_exp_ov = 1'b0;
        moore_exp_no = 1'b0;
    endtask

    task automatic clear_masks();
        mask_m_ov = '0;
        mask_y_ov = '0;
        mask_m_no = '0;
        mask_y_no = '0;
    endtask

    task automatic check_bit(input string name, input int idx, input logic got, input logic exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s bit=%0d: got %b expected %b", name, idx, got, exp);
        end
    endtask

    task automatic step(input logic b, input int idx);
        logic exp_m_ov;
        logic exp_m_no;
        @(negedge clk);
        bus_ov.x = b;
        bus_no.x = b;
        #1;
        exp_m_ov = would_hit(hist_ov, b);
        exp_m_no = would_hit(hist_no, b);
        check_bit("mealy_ov", idx, bus_ov.y_mealy, exp_m_ov);
        check_bit("mealy_no", idx, bus_no.y_mealy, exp_m_no);
        check_bit("moore_ov", idx, bus_ov.y_moore, moore_exp_ov);
        check_bit("moore_no", idx, bus_no.y_moore, moore_exp_no);
        if (idx > 0 && idx < 32) begin
            mask_m_ov[idx] = (bus_ov.y_mealy === 1'b1);
            mask_m_no[idx] = (bus_no.y_mealy === 1'b1);
            mask_y_ov[idx] = (bus_ov.y_moore === 1'b1);
            mask_y_no[idx] = (bus_no.y_moore === 1'b1);
        end
        @(posedge clk);
        hist_ov.push_back(int'(b));
        hist_no.push_back(int'(b));
        moore_exp_ov = exp_m_ov;
        moore_exp_no = exp_m_no;
        if (exp_m_no) hist_no.delete();
        while (hist_ov.size() > 2) void'(hist_ov.pop_front());
        while (hist_no.size() > 2) void'(hist_no.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        bus_ov.x = 1'b0;
        bus_no.x = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_masks(input string name, input logic [31:0] m_ov, input logic [31:0] m_no);
        compared += 4;
        if (mask_m_ov !== m_ov) begin
            mismatched++;
            $display("[TB] FAIL %s mealy_ov pulses: got %h expected %h", name, mask_m_ov, m_ov);
        end
        if (mask_y_ov !== (m_ov << 1)) begin
            mismatched++;
            $display("[TB] FAIL %s moore_ov pulses: got %h expected %h", name, mask_y_ov, m_ov << 1);
        end
        if (mask_m_no !== m_no) begin
            mismatched++;
            $display("[TB] FAIL %s mealy_no pulses: got %h expected %h", name, mask_m_no, m_no);
        end
        if (mask_y_no !== (m_no << 1)) begin
            mismatched++;
            $display("[TB] FAIL %s moore_no pulses: got %h expected %h", name, mask_y_no, m_no << 1);
        end
    endtask

    task automatic test_reset();
        #1;
        check_bit("reset_mealy_ov", 0, bus_ov.y_mealy, 1'b0);
        check_bit("reset_moore_ov", 0, bus_ov.y_moore, 1'b0);
        check_bit("reset_mealy_no", 0, bus_no.y_mealy, 1'b0);
        check_bit("reset_moore_no", 0, bus_no.y_moore, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1);
        step(1'b0, 2);
        // Matcher now sits one bit from a hit; a '1' shows it, then reset must clear it at once.
        @(negedge clk);
        bus_ov.x = 1'b1;
        bus_no.x = 1'b1;
        #1;
        check_bit("armed_mealy_ov", 3, bus_ov.y_mealy, 1'b1);
        check_bit("armed_mealy_no", 3, bus_no.y_mealy, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_bit("async_mealy_ov", 3, bus_ov.y_mealy, 1'b0);
        check_bit("async_mealy_no", 3, bus_no.y_mealy, 1'b0);
        check_bit("async_moore_ov", 3, bus_ov.y_moore, 1'b0);
        check_bit("async_moore_no", 3, bus_no.y_moore, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_bit("held_moore_ov", 3, bus_ov.y_moore, 1'b0);
        check_bit("held_moore_no", 3, bus_no.y_moore, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        clear_masks();
        step(1'b1, 1);
        step(1'b0, 2);
        check_masks("after_reset", 32'h0, 32'h0);
    endtask

    task automatic test_basic_and_overlap();
        logic [8:0] bits;
        do_reset();
        clear_masks();
        bits = 9'b0_1010_1001;
        for (int i = 0; i < 9; i++) step(bits[i], i + 1);
        check_masks("basic_overlap", (32'd1 << 6) | (32'd1 << 8), 32'd1 << 6);
    endtask

    task automatic test_full_stream();
        logic [11:0] bits;
        do_reset();
        clear_masks();
        bits = 12'b0101_1010_1001;
        for (int i = 0; i < 12; i++) step(bits[i], i + 1);
        check_masks("full_stream", (32'd1 << 6) | (32'd1 << 8) | (32'd1 << 11),
                    (32'd1 << 6) | (32'd1 << 11));
    endtask

    task automatic test_non_overlap();
        logic [5:0] bits;
        do_reset();
        clear_masks();
        bits = 6'b01_0101;
        for (int i = 0; i < 6; i++) step(bits[i], i + 1);
        check_masks("back_to_back", (32'd1 << 3) | (32'd1 << 5), 32'd1 << 3);
    endtask

    task automatic test_negative();
        logic [4:0] ones;
        logic [4:0] gap;
        ones = 5'b0_1111;
        gap  = 5'b0_1001;
        do_reset();
        clear_masks();
        for (int i = 0; i < 5; i++) step(ones[i], i + 1);
        check_masks("run_of_ones", 32'h0, 32'h0);
        do_reset();
        clear_masks();
        for (int i = 0; i < 5; i++) step(gap[i], i + 1);
        check_masks("one_double_zero_one", 32'h0, 32'h0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end
            step(logic'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus_ov.x = 1'b0;
        bus_no.x = 1'b0;
        clear_masks();
        test_reset();
        test_basic_and_overlap();
        test_full_stream();
        test_non_overlap();
        test_negative();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
